// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared address map and parameter checks for io_port_bank
package io_pkg;

   localparam int ADDR_W      = 4;
   localparam int IN_BASE     = 0;
   localparam int OUT_BASE    = 8;
   localparam int STATUS_ADDR = 15;

   // Legal configurations: 1..8 inputs that fit in one status word, 1..7 outputs, 4-bit map
   function automatic bit params_ok(input int width, input int num_in,
                                    input int num_out, input int addr_w);
      return (num_in >= 1) && (num_in <= 8) && (num_in <= width) &&
             (num_out >= 1) && (num_out <= 7) && (addr_w == ADDR_W);
   endfunction

endpackage

// File: rtl/io_sync.sv
// rtl/io_sync.sv - WIDTH-bit two-flop synchroniser, async active-low reset
module io_sync #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   // two-stage capture of the asynchronous board inputs
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/io_port_bank.sv
// rtl/io_port_bank.sv - memory-mapped input/output port bank; IO_IRQ_EN adds change flags, mask and irq
module io_port_bank #(
   parameter int WIDTH   = 8,
   parameter int NUM_IN  = 4,
   parameter int NUM_OUT = 4,
   parameter int ADDR_W  = io_pkg::ADDR_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [ADDR_W-1:0]        addr,
   input  logic                     we,
   input  logic                     re,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   input  logic [NUM_IN*WIDTH-1:0]  in_bus,
   output logic [NUM_OUT*WIDTH-1:0] out_bus,
   output logic                     irq
);

   import io_pkg::*;

   if (!params_ok(WIDTH, NUM_IN, NUM_OUT, ADDR_W)) begin : g_bad_params
      $error("io_port_bank: WIDTH/NUM_IN/NUM_OUT/ADDR_W out of range");
   end

   logic [NUM_IN-1:0][WIDTH-1:0]  w_sync;
   logic [NUM_OUT-1:0][WIDTH-1:0] r_out;
   logic [WIDTH-1:0]              r_rdata;
   logic [WIDTH-1:0]              w_rd_val;

   // one synchroniser per input port
   for (genvar i = 0; i < NUM_IN; i++) begin : g_sync
      io_sync #(.WIDTH(WIDTH)) u_sync (
         .clk     (clk),
         .i_rst_n (reset),
         .i_d     (in_bus[i*WIDTH +: WIDTH]),
         .o_q     (w_sync[i])
      );
   end

`ifdef IO_IRQ_EN
   logic [NUM_IN-1:0][WIDTH-1:0] r_prev;
   logic [NUM_IN-1:0]            r_flag;
   logic [NUM_IN-1:0]            r_mask;
   logic                         r_irq;
   logic [NUM_IN-1:0]            w_change;
   logic [NUM_IN-1:0]            w_clr;
   logic                         w_status_sel;

   assign w_status_sel = (addr == ADDR_W'(STATUS_ADDR));

   // per-port change: synchronised value differs from last cycle's value
   always_comb begin
      w_change = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         w_change[i] = (w_sync[i] != r_prev[i]);
      end
   end

   // a status read clears only the flags it actually returned
   assign w_clr = (re && w_status_sel) ? r_flag : '0;

   // previous-value register for change detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_prev <= '0;
      else        r_prev <= w_sync;
   end

   // sticky flags; a new change beats a simultaneous clear
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_flag <= '0;
      else        r_flag <= (r_flag & ~w_clr) | w_change;
   end

   // interrupt mask loaded from the low bits of a status write
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                  r_mask <= '0;
      else if (we && w_status_sel) r_mask <= wdata[NUM_IN-1:0];
   end

   // registered level interrupt
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_irq <= 1'b0;
      else        r_irq <= |(r_flag & r_mask);
   end

   assign irq = r_irq;
`else
   assign irq = 1'b0;
`endif

   // read mux: inputs, output read-back, status; unmapped addresses give 0
   always_comb begin
      w_rd_val = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (addr == ADDR_W'(IN_BASE + i)) w_rd_val = w_sync[i];
      end
      for (int j = 0; j < NUM_OUT; j++) begin
         if (addr == ADDR_W'(OUT_BASE + j)) w_rd_val = r_out[j];
      end
`ifdef IO_IRQ_EN
      if (w_status_sel) w_rd_val = WIDTH'(r_flag);
`endif
   end

   // output port registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_out <= '0;
      end else if (we) begin
         for (int j = 0; j < NUM_OUT; j++) begin
            if (addr == ADDR_W'(OUT_BASE + j)) r_out[j] <= wdata;
         end
      end
   end

   // read data register, held between reads; sees pre-write value on we+re
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)  r_rdata <= '0;
      else if (re) r_rdata <= w_rd_val;
   end

   assign rdata   = r_rdata;
   assign out_bus = r_out;

endmodule

// File: tb/tb_io_port_bank.sv
// tb/tb_io_port_bank.sv - self-checking bench for io_port_bank
module tb_io_port_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  addr;
   logic        we;
   logic        re;
   logic [7:0]  wdata;
   logic [7:0]  rdata;
   logic [31:0] in_bus;
   logic [31:0] out_bus;
   logic        irq;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   io_port_bank #(.WIDTH(8), .NUM_IN(4), .NUM_OUT(4), .ADDR_W(4)) dut (
      .clk     (clk),
      .reset   (reset),
      .addr    (addr),
      .we      (we),
      .re      (re),
      .wdata   (wdata),
      .rdata   (rdata),
      .in_bus  (in_bus),
      .out_bus (out_bus),
      .irq     (irq)
   );

   typedef struct {
      bit          we;
      bit          re;
      logic [3:0]  addr;
      logic [7:0]  wdata;
      logic [31:0] inb;
      logic [7:0]  exp_rd;
      logic [31:0] exp_out;
   } vec_t;

   vec_t tv[20];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input bit w, input bit r, input logic [3:0] a,
                       input logic [7:0] wd, input logic [31:0] inb);
      @(negedge clk);
      we = w; re = r; addr = a; wdata = wd; in_bus = inb;
      @(posedge clk);
      #1;
   endtask

   initial begin
      //          we re addr  wdata  in_bus        rdata  out_bus
      tv[0]  = '{0, 0, 4'd0,  8'h00, 32'h00000005, 8'h00, 32'h00000000};
      tv[1]  = '{0, 0, 4'd0,  8'h00, 32'h00000005, 8'h00, 32'h00000000};
      tv[2]  = '{0, 1, 4'd0,  8'h00, 32'h00000005, 8'h05, 32'h00000000};
      tv[3]  = '{1, 0, 4'd9,  8'h3C, 32'h00000005, 8'h05, 32'h00003C00};
      tv[4]  = '{0, 1, 4'd9,  8'h00, 32'h00000005, 8'h3C, 32'h00003C00};
      tv[5]  = '{0, 1, 4'd12, 8'h00, 32'h00000005, 8'h00, 32'h00003C00};
      tv[6]  = '{1, 0, 4'd8,  8'hA5, 32'h00000005, 8'h00, 32'h00003CA5};
      tv[7]  = '{1, 0, 4'd11, 8'h81, 32'h00000005, 8'h00, 32'h81003CA5};
      tv[8]  = '{0, 1, 4'd11, 8'h00, 32'h00000005, 8'h81, 32'h81003CA5};
      tv[9]  = '{1, 0, 4'd5,  8'hFF, 32'h00000005, 8'h81, 32'h81003CA5};
      tv[10] = '{0, 1, 4'd5,  8'h00, 32'h00000005, 8'h00, 32'h81003CA5};
      tv[11] = '{1, 1, 4'd10, 8'h77, 32'h00000005, 8'h00, 32'h81773CA5};
      tv[12] = '{0, 1, 4'd10, 8'h00, 32'h00000005, 8'h77, 32'h81773CA5};
      tv[13] = '{0, 0, 4'd0,  8'h00, 32'h11223344, 8'h77, 32'h81773CA5};
      tv[14] = '{0, 0, 4'd0,  8'h00, 32'h11223344, 8'h77, 32'h81773CA5};
      tv[15] = '{0, 1, 4'd3,  8'h00, 32'h11223344, 8'h11, 32'h81773CA5};
      tv[16] = '{0, 1, 4'd1,  8'h00, 32'h11223344, 8'h33, 32'h81773CA5};
      tv[17] = '{0, 1, 4'd0,  8'h00, 32'h11223344, 8'h44, 32'h81773CA5};
      tv[18] = '{1, 0, 4'd12, 8'hEE, 32'h11223344, 8'h44, 32'h81773CA5};
      tv[19] = '{0, 1, 4'd12, 8'h00, 32'h11223344, 8'h00, 32'h81773CA5};

      reset = 1'b0; we = 1'b0; re = 1'b0; addr = '0; wdata = '0; in_bus = 32'h5;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_bus", out_bus, 32'h0);
      chk("reset_rdata", {24'h0, rdata}, 32'h0);
      chk("reset_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      for (int k = 0; k < 20; k++) begin
         step(tv[k].we, tv[k].re, tv[k].addr, tv[k].wdata, tv[k].inb);
         chk($sformatf("vec%0d_rdata", k), {24'h0, rdata}, {24'h0, tv[k].exp_rd});
         chk($sformatf("vec%0d_out_bus", k), out_bus, tv[k].exp_out);
      end

`ifdef IO_IRQ_EN
      // settle inputs and clear stale flags
      step(0, 0, 4'd0, 8'h00, 32'h00000005);
      repeat (3) step(0, 0, 4'd0, 8'h00, 32'h00000005);
      step(0, 1, 4'd15, 8'h00, 32'h00000005);
      step(0, 1, 4'd15, 8'h00, 32'h00000005);
      chk("flags_cleared", {24'h0, rdata}, 32'h0);

      // mask 0x03 (upper wdata bits ignored), port0 5->3
      step(1, 0, 4'd15, 8'hF3, 32'h00000005);
      step(0, 0, 4'd0, 8'h00, 32'h00000003);
      step(0, 0, 4'd0, 8'h00, 32'h00000003);
      step(0, 0, 4'd0, 8'h00, 32'h00000003);
      chk("irq_before_flag_to_irq", {31'h0, irq}, 32'h0);
      step(0, 0, 4'd0, 8'h00, 32'h00000003);
      chk("irq_after_change", {31'h0, irq}, 32'h1);
      step(0, 1, 4'd15, 8'h00, 32'h00000003);
      chk("status_port0", {24'h0, rdata}, 32'h01);
      chk("irq_still_high_at_clear", {31'h0, irq}, 32'h1);
      step(0, 0, 4'd0, 8'h00, 32'h00000003);
      chk("irq_low_after_clear", {31'h0, irq}, 32'h0);

      // masked change on port2
      step(1, 0, 4'd15, 8'h01, 32'h00000003);
      repeat (4) step(0, 0, 4'd0, 8'h00, 32'h00010003);
      chk("irq_masked", {31'h0, irq}, 32'h0);
      step(0, 1, 4'd15, 8'h00, 32'h00010003);
      chk("status_port2", {24'h0, rdata}, 32'h04);
      step(0, 0, 4'd0, 8'h00, 32'h00010003);
      chk("irq_masked_after", {31'h0, irq}, 32'h0);

      // set wins over clear
      repeat (4) step(0, 0, 4'd0, 8'h00, 32'h00010103);
      step(0, 1, 4'd15, 8'h00, 32'h00010103);
      chk("status_port1_rise", {24'h0, rdata}, 32'h02);
      step(0, 0, 4'd0, 8'h00, 32'h00010003);
      step(0, 0, 4'd0, 8'h00, 32'h00010003);
      step(0, 1, 4'd15, 8'h00, 32'h00010003);
      chk("setwins_old_flags", {24'h0, rdata}, 32'h00);
      step(0, 1, 4'd15, 8'h00, 32'h00010003);
      chk("setwins_flag_kept", {24'h0, rdata}, 32'h02);
`else
      step(1, 0, 4'd15, 8'hFF, 32'h11223344);
      chk("status_write_no_out", out_bus, 32'h81773CA5);
      step(0, 1, 4'd15, 8'h00, 32'h11223344);
      chk("status_reads_zero", {24'h0, rdata}, 32'h0);
      chk("irq_tied_low", {31'h0, irq}, 32'h0);
`endif

      // reset mid-operation
      step(1, 0, 4'd8, 8'hFF, 32'h12345678);
      repeat (4) step(0, 0, 4'd0, 8'h00, 32'h12345678);
`ifdef IO_IRQ_EN
      step(1, 0, 4'd15, 8'h0F, 32'h12345678);
      step(0, 0, 4'd0, 8'h00, 32'h12345678);
      chk("irq_before_reset", {31'h0, irq}, 32'h1);
`endif
      step(0, 1, 4'd0, 8'h00, 32'h12345678);
      chk("rdata_before_reset", {24'h0, rdata}, 32'h78);
      chk("out_before_reset", out_bus[7:0], 32'hFF);
      @(negedge clk);
      we = 1'b0; re = 1'b0;
      #2 reset = 1'b0;
      #1;
      chk("async_reset_out_bus", out_bus, 32'h0);
      chk("async_reset_rdata", {24'h0, rdata}, 32'h0);
      chk("async_reset_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      reset = 1'b1;
      repeat (3) step(0, 0, 4'd0, 8'h00, 32'h12345678);
`ifdef IO_IRQ_EN
      step(0, 1, 4'd15, 8'h00, 32'h12345678);
      chk("post_reset_flags", {24'h0, rdata}, 32'h0F);
      chk("post_reset_irq_masked", {31'h0, irq}, 32'h0);
`endif
      step(0, 1, 4'd2, 8'h00, 32'h12345678);
      chk("post_reset_in2", {24'h0, rdata}, 32'h34);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
